// File: rtl/card_match_tracker_if.sv
// Player/host-side signals of the card match tracker: pick handshake,
// pair-table write port and the new-game request.
interface card_match_tracker_if #(
  parameter int IDX_W = 5
);
  logic             restart;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_ready;
  logic             pair_wr;
  logic [IDX_W-1:0] pair_wr_idx;
  logic [IDX_W-1:0] pair_wr_id;

  // Driver side (player / host)
  modport master (
    output restart, pick_valid, pick_idx, pair_wr, pair_wr_idx, pair_wr_id,
    input  pick_ready
  );

  // Tracker side
  modport slave (
    input  restart, pick_valid, pick_idx, pair_wr, pair_wr_idx, pair_wr_id,
    output pick_ready
  );
endinterface

// File: rtl/card_match_tracker.sv
// Memory-style card game tracker: the player turns over two cards per move;
// equal pair IDs eliminate both, otherwise both stay visible for SHOW_CYCLES
// before flipping back. Pair table is writable between games.
module card_match_tracker #(
  parameter int NUM_CARDS   = 16,
  parameter int IDX_W       = 5,
  parameter int SHOW_CYCLES = 8,
  parameter int MOVE_W      = 8
) (
  input  logic                 new_clk,
  input  logic                 rst,
  card_match_tracker_if.slave  bus,
  output logic [NUM_CARDS-1:0] face_up,
  output logic [NUM_CARDS-1:0] eliminated,
  output logic                 match_pulse,
  output logic                 mismatch_pulse,
  output logic                 reject_pulse,
  output logic [IDX_W-1:0]     pairs_found,
  output logic [MOVE_W-1:0]    moves,
  output logic                 game_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] CARD_LIM  = IDX_W'(NUM_CARDS);
  localparam logic [IDX_W-1:0] PAIR_GOAL = IDX_W'(NUM_CARDS / 2);
  localparam logic [7:0]       HOLD_LOAD = 8'(SHOW_CYCLES);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       table_q [NUM_CARDS];
  logic [IDX_W-1:0]       first_idx_q, first_idx_d;
  logic [IDX_W-1:0]       first_id_q, first_id_d;
  logic [NUM_CARDS-1:0]   face_q, face_d;
  logic [NUM_CARDS-1:0]   elim_q, elim_d;
  logic [IDX_W-1:0]       pairs_q, pairs_d;
  logic [MOVE_W-1:0]      moves_q, moves_d;
  logic [7:0]             hold_q, hold_d;
  logic                   match_q, match_d;
  logic                   mismatch_q, mismatch_d;
  logic                   reject_q, reject_d;
  logic                   done_q, done_d;

  logic [NUM_CARDS-1:0]   pick_oh;
  logic [NUM_CARDS-1:0]   first_oh;
  logic [NUM_CARDS-1:0]   wr_oh;
  logic [IDX_W-1:0]       pick_id;
  logic                   pick_bad;
  logic                   pick_fire;
  logic                   wr_en;

  // One-hot decodes of the picked card, the card already up and the write target
  for (genvar gi = 0; gi < NUM_CARDS; gi++) begin : g_decode
    assign pick_oh[gi]  = (bus.pick_idx    == IDX_W'(gi));
    assign first_oh[gi] = (first_idx_q     == IDX_W'(gi));
    assign wr_oh[gi]    = (bus.pair_wr_idx == IDX_W'(gi));
  end

  // Pair ID of the card currently being picked
  always_comb begin
    pick_id = '0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (pick_oh[i]) pick_id = table_q[i];
    end
  end

  // Picks are only taken while a card can be turned and no table write or
  // restart competes for the cycle.
  assign bus.pick_ready = ((state_q == ST_IDLE) || (state_q == ST_ONE)) &&
                          !bus.pair_wr && !bus.restart;
  assign pick_fire = bus.pick_valid && bus.pick_ready;

  assign pick_bad = (bus.pick_idx >= CARD_LIM) ||
                    (|(pick_oh & elim_q)) ||
                    ((state_q == ST_ONE) && (bus.pick_idx == first_idx_q));

  // The table may only be rewritten before any pair of the game is found
  assign wr_en = bus.pair_wr && !bus.restart && (state_q == ST_IDLE) &&
                 (pairs_q == '0) && (bus.pair_wr_idx < CARD_LIM);

  // Pair table: reset default pairs cards 2k and 2k+1; restart leaves it alone
  always_ff @(posedge new_clk) begin
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (rst) begin
        table_q[i] <= IDX_W'(i / 2);
      end else if (wr_en && wr_oh[i]) begin
        table_q[i] <= bus.pair_wr_id;
      end
    end
  end

  // Next-state and game bookkeeping
  always_comb begin
    state_d     = state_q;
    first_idx_d = first_idx_q;
    first_id_d  = first_id_q;
    face_d      = face_q;
    elim_d      = elim_q;
    pairs_d     = pairs_q;
    moves_d     = moves_q;
    hold_d      = hold_q;
    match_d     = 1'b0;
    mismatch_d  = 1'b0;
    reject_d    = 1'b0;

    if (bus.restart) begin
      state_d     = ST_IDLE;
      first_idx_d = '0;
      first_id_d  = '0;
      face_d      = '0;
      elim_d      = '0;
      pairs_d     = '0;
      moves_d     = '0;
      hold_d      = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_fire) begin
            if (pick_bad) begin
              reject_d = 1'b1;
            end else begin
              first_idx_d = bus.pick_idx;
              first_id_d  = pick_id;
              face_d      = face_q | pick_oh;
              state_d     = ST_ONE;
            end
          end
        end
        ST_ONE: begin
          if (pick_fire) begin
            if (pick_bad) begin
              reject_d = 1'b1;
            end else begin
              moves_d = (&moves_q) ? moves_q : moves_q + 1'b1;
              if (pick_id == first_id_q) begin
                elim_d  = elim_q | pick_oh | first_oh;
                face_d  = face_q & ~(pick_oh | first_oh);
                pairs_d = pairs_q + 1'b1;
                match_d = 1'b1;
                state_d = (pairs_d == PAIR_GOAL) ? ST_DONE : ST_IDLE;
              end else begin
                face_d     = face_q | pick_oh;
                mismatch_d = 1'b1;
                hold_d     = HOLD_LOAD;
                state_d    = ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          // Last shown cycle: both cards flip back as we return to IDLE
          if (hold_q <= 8'd1) begin
            face_d  = '0;
            hold_d  = '0;
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
        ST_DONE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end

    done_d = (state_d == ST_DONE);
  end

  // State register; rst outranks every other request
  always_ff @(posedge new_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      first_idx_q <= '0;
      first_id_q  <= '0;
      face_q      <= '0;
      elim_q      <= '0;
      pairs_q     <= '0;
      moves_q     <= '0;
      hold_q      <= '0;
      match_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      reject_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_idx_q <= first_idx_d;
      first_id_q  <= first_id_d;
      face_q      <= face_d;
      elim_q      <= elim_d;
      pairs_q     <= pairs_d;
      moves_q     <= moves_d;
      hold_q      <= hold_d;
      match_q     <= match_d;
      mismatch_q  <= mismatch_d;
      reject_q    <= reject_d;
      done_q      <= done_d;
    end
  end

  assign face_up        = face_q;
  assign eliminated     = elim_q;
  assign match_pulse    = match_q;
  assign mismatch_pulse = mismatch_q;
  assign reject_pulse   = reject_q;
  assign pairs_found    = pairs_q;
  assign moves          = moves_q;
  assign game_done      = done_q;

endmodule

// File: tb/tb_card_match_tracker.sv
// Bench for card_match_tracker: directed game scenarios followed by random
// play, every cycle compared against a card-level model of the game rules.
module tb_card_match_tracker;
  localparam int N    = 16;
  localparam int IW   = 5;
  localparam int SHOW = 8;
  localparam int MW   = 8;

  logic          new_clk = 1'b0;
  logic          rst;
  logic [N-1:0]  face_up, eliminated;
  logic          match_pulse, mismatch_pulse, reject_pulse;
  logic [IW-1:0] pairs_found;
  logic [MW-1:0] moves;
  logic          game_done;

  always #5 new_clk = ~new_clk;

  card_match_tracker_if #(.IDX_W(IW)) bus ();

  card_match_tracker #(
    .NUM_CARDS(N), .IDX_W(IW), .SHOW_CYCLES(SHOW), .MOVE_W(MW)
  ) dut (
    .new_clk(new_clk), .rst(rst), .bus(bus),
    .face_up(face_up), .eliminated(eliminated),
    .match_pulse(match_pulse), .mismatch_pulse(mismatch_pulse),
    .reject_pulse(reject_pulse), .pairs_found(pairs_found),
    .moves(moves), .game_done(game_done)
  );

  // Card-level model: which cards are up, which are gone, time left on show
  int tbl [N];
  bit gone [N];
  int up [$];
  int hold_left;
  bit done_m;
  int pairs_m, moves_m;
  bit mp, mmp, rp;

  int n_vec = 0;
  int n_bad = 0;
  int step_no = 0;

  function automatic void model_clear_game();
    up.delete();
    hold_left = 0;
    done_m = 0;
    pairs_m = 0;
    moves_m = 0;
    for (int i = 0; i < N; i++) gone[i] = 0;
  endfunction

  function automatic void model_update(bit r, bit rs, bit v, int idx, bit w, int widx, int wid);
    mp = 0; mmp = 0; rp = 0;
    if (r) begin
      for (int i = 0; i < N; i++) tbl[i] = i / 2;
      model_clear_game();
    end else if (rs) begin
      model_clear_game();
    end else if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) up.delete();
    end else if (done_m) begin
      // game over: nothing moves until restart
    end else if (w) begin
      if (up.size() == 0 && pairs_m == 0 && widx < N) tbl[widx] = wid;
    end else if (v) begin
      if (idx >= N) rp = 1;
      else if (gone[idx] || (up.size() == 1 && up[0] == idx)) rp = 1;
      else if (up.size() == 0) up.push_back(idx);
      else begin
        if (moves_m < (1 << MW) - 1) moves_m++;
        if (tbl[up[0]] == tbl[idx]) begin
          gone[up[0]] = 1;
          gone[idx] = 1;
          up.delete();
          pairs_m++;
          mp = 1;
          if (pairs_m == N / 2) done_m = 1;
        end else begin
          up.push_back(idx);
          mmp = 1;
          hold_left = SHOW;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] ef, ee;
    ef = '0;
    ee = '0;
    foreach (up[k]) ef[up[k]] = 1'b1;
    for (int i = 0; i < N; i++) ee[i] = gone[i];
    check("face_up", 32'(face_up), 32'(ef));
    check("eliminated", 32'(eliminated), 32'(ee));
    check("pulses", 32'({match_pulse, mismatch_pulse, reject_pulse}), 32'({mp, mmp, rp}));
    check("pairs_found", 32'(pairs_found), 32'(pairs_m));
    check("moves", 32'(moves), 32'(moves_m));
    check("game_done", 32'(game_done), 32'(done_m));
  endtask

  // One clock cycle: drive inputs, check ready, advance model and DUT, compare
  task automatic step(input bit r, input bit rs, input bit v, input int idx,
                      input bit w, input int widx, input int wid);
    bit exp_ready;
    step_no++;
    rst             = r;
    bus.restart     = rs;
    bus.pick_valid  = v;
    bus.pick_idx    = IW'(idx);
    bus.pair_wr     = w;
    bus.pair_wr_idx = IW'(widx);
    bus.pair_wr_id  = IW'(wid);
    #1;
    exp_ready = !done_m && (hold_left == 0) && !w && !rs;
    check("pick_ready", 32'(bus.pick_ready), 32'(exp_ready));
    model_update(r, rs, v, idx, w, widx, wid);
    @(posedge new_clk);
    #1;
    check_outputs();
    $display("step %0d rst=%0b rs=%0b v=%0b idx=%0d wr=%0b face=%h elim=%h pulses=%b pairs=%0d moves=%0d done=%0b",
             step_no, r, rs, v, idx, w, face_up, eliminated,
             {match_pulse, mismatch_pulse, reject_pulse}, pairs_found, moves, game_done);
  endtask

  task automatic do_rst();      step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_restart();  step(0, 1, 0, 0, 0, 0, 0); endtask
  task automatic idle();        step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic pick(input int i);          step(0, 0, 1, i, 0, 0, 0); endtask
  task automatic wr(input int i, input int id); step(0, 0, 0, 0, 1, i, id); endtask

  initial begin
    int pa [7];
    int pb [7];
    rst = 1'b1;
    bus.restart = 1'b0; bus.pick_valid = 1'b0; bus.pick_idx = '0;
    bus.pair_wr = 1'b0; bus.pair_wr_idx = '0; bus.pair_wr_id = '0;
    @(posedge new_clk);
    @(posedge new_clk);
    #1;

    // Reset state
    do_rst();
    do_rst();
    idle();

    // Simple match of cards 0 and 1
    pick(0);
    pick(1);
    idle();

    // Mismatch 0/2: shown for SHOW cycles while picks are ignored
    do_rst();
    pick(0);
    pick(2);
    for (int k = 0; k < SHOW; k++) pick($urandom_range(0, N - 1));
    idle();

    // Rejections: same card twice, out of range, eliminated card
    pick(0);
    pick(0);
    pick(20);
    pick(1);
    pick(0);
    pick(1);
    idle();

    // Custom table: 0 and 10 share ID 3, table write during ONE is ignored
    do_rst();
    wr(0, 3); wr(10, 3); wr(1, 5); wr(6, 0); wr(7, 0); wr(20, 1);
    pick(0);
    wr(10, 7);
    step(0, 0, 1, 10, 1, 10, 7);
    pick(10);
    wr(2, 9);

    // Finish the game with the remaining custom pairs
    pa = '{1, 2, 4, 6, 8, 12, 14};
    pb = '{11, 3, 5, 7, 9, 13, 15};
    for (int k = 0; k < 7; k++) begin
      pick(pa[k]);
      pick(pb[k]);
    end
    pick(2);
    pick(3);
    idle();

    // Restart keeps the custom table
    do_restart();
    pick(0);
    pick(10);
    idle();

    // rst in the middle of a mismatch show restores the default table
    do_restart();
    pick(0);
    pick(2);
    idle(); idle(); idle();
    do_rst();
    pick(0);
    pick(1);
    idle();

    // Random play
    for (int k = 0; k < 1500; k++) begin
      int roll;
      roll = $urandom_range(0, 999);
      step(roll < 4, (roll >= 4) && (roll < 14), $urandom_range(0, 9) < 6,
           $urandom_range(0, 17), $urandom_range(0, 19) == 0,
           $urandom_range(0, 17), $urandom_range(0, 9));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/card_match_tracker.md
CARD_MATCH_TRACKER -- requirements
Module: card_match_tracker

Interface
REQ-001 Parameter NUM_CARDS, default 16, number of cards on the board; even, 2..31.
REQ-002 Parameter IDX_W, default 5, width of card index and pair ID.
REQ-003 Parameter SHOW_CYCLES, default 8, cycles a mismatched pair stays face-up; 1..255.
REQ-004 Parameter MOVE_W, default 8, width of the move counter.
REQ-005 new_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 restart  in  1  synchronous new-game request; clears game state, keeps pair table.
REQ-008 pick_valid  in  1  player selects a card this cycle.
REQ-009 pick_idx  in  IDX_W  index of the selected card.
REQ-010 pick_ready  out  1  combinational; a pick is accepted only when pick_valid && pick_ready.
REQ-011 pair_wr  in  1  write a pair-table entry.
REQ-012 pair_wr_idx  in  IDX_W  card index to write.
REQ-013 pair_wr_id  in  IDX_W  pair ID to store; cards with equal IDs match.
REQ-014 face_up  out  NUM_CARDS  registered; bit i set while card i is turned over.
REQ-015 eliminated  out  NUM_CARDS  registered; bit i set once card i is matched; sticky.
REQ-016 match_pulse, mismatch_pulse, reject_pulse  out  1 each  registered single-cycle events.
REQ-017 pairs_found  out  IDX_W  registered count of matched pairs.
REQ-018 moves  out  MOVE_W  registered count of completed two-card turns.
REQ-019 game_done  out  1  registered; high in DONE.

Function
REQ-020 The FSM SHALL have states IDLE (no card up), ONE (one card up), HOLD (mismatch shown), DONE.
REQ-021 pick_ready SHALL be 1 only in IDLE or ONE and only when pair_wr and restart are both 0.
REQ-022 An accepted pick SHALL be rejected (reject_pulse=1 next cycle, no other state change) if pick_idx >= NUM_CARDS, card already eliminated, or pick_idx equals the card up in ONE.
REQ-023 IDLE + valid pick: store first index, set its face_up bit, go to ONE.
REQ-024 ONE + valid pick: moves increments (saturating at all-ones); pair IDs of both cards compared in that same edge.
REQ-025 On match: both eliminated bits set, both face_up bits cleared, pairs_found increments, match_pulse=1 next cycle; go to DONE if the new pairs_found equals NUM_CARDS/2, else IDLE.
REQ-026 On mismatch: second face_up bit set, mismatch_pulse=1 next cycle, load hold counter with SHOW_CYCLES, go to HOLD.
REQ-027 HOLD: counter decrements each cycle; both cards SHALL be face-up for exactly SHOW_CYCLES cycles, then both face_up bits clear and state returns to IDLE in the same edge.
REQ-028 Picks presented in HOLD or DONE SHALL be ignored with no reject_pulse (pick_ready=0).
REQ-029 pair_wr SHALL update the table only in IDLE with pairs_found=0 and pair_wr_idx < NUM_CARDS; otherwise ignored.
REQ-030 pair_wr and pick_valid in the same cycle: write takes effect, pick is not accepted.
REQ-031 restart SHALL clear face_up, eliminated, pulses, pairs_found, moves, hold counter and return to IDLE from any state; restart has priority over pick and pair_wr.
REQ-032 Pulses SHALL be mutually exclusive and low in every cycle without a triggering event.

Reset
REQ-033 rst SHALL clear every output and counter to 0, state to IDLE, and load the pair table with pair_id[i] = i>>1 (cards 2k and 2k+1 match).
REQ-034 rst SHALL take priority over restart, pick and pair_wr, and abort any in-progress HOLD.

Verification
REQ-035 After rst, pick 0 then 1 -> match_pulse once, eliminated[1:0]=2'b11, pairs_found=1, moves=1, face_up=0.
REQ-036 After rst, pick 0 then 2 -> mismatch_pulse, face_up bits 0,2 high exactly 8 cycles, pick_valid ignored during hold, then IDLE.
REQ-037 Pick 0, pick 0 again -> reject_pulse, state stays ONE; pick eliminated card or idx 20 -> reject_pulse.
REQ-038 Write table (0,10)=ID 3, others unique pairs; pick 0 then 10 -> match; pair_wr during ONE ignored.
REQ-039 Match all 8 pairs -> game_done=1 after eighth match_pulse, picks ignored; restart -> IDLE, counters 0, table unchanged.
REQ-040 Assert rst mid-HOLD -> all outputs 0 next cycle, default table restored.
